// File: rtl/axis_frame_capture.sv
// AXI4-Stream capture sink for FFT output frames: aligns on tlast, stores SAMP
// complex samples in block RAM, flags misplaced tlast, and offers synchronous readback.
module axis_frame_capture #(
  parameter int WIDTH       = 16,
  parameter int FFT_LEN     = 64,
  parameter int FRAMES      = 32,
  parameter int SAMP        = FRAMES * FFT_LEN,
  parameter int ALIGN_TLAST = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clear,
  input  logic [2*WIDTH-1:0]           s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  input  logic [$clog2(SAMP)-1:0]      rd_addr,
  output logic [2*WIDTH-1:0]           rd_data,
  output logic                         full,
  output logic                         capturing,
  output logic [$clog2(FRAMES+1)-1:0]  frame_cnt,
  output logic                         tlast_err
);

  localparam int AW = $clog2(SAMP);
  localparam int IW = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam int FW = $clog2(FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ALIGN   = 2'd1,
    CAPTURE = 2'd2,
    FULL    = 2'd3
  } state_t;

  state_t            state;
  logic [AW-1:0]     wr_addr;
  logic [IW-1:0]     idx;
  logic              beat;
  logic              wr_en;
  logic              last_idx;
  logic              last_addr;

  logic [2*WIDTH-1:0] mem [SAMP];

  assign beat      = s_axis_tvalid & s_axis_tready;
  assign last_idx  = (idx == IW'(FFT_LEN - 1));
  assign last_addr = (wr_addr == AW'(SAMP - 1));
  // clear and en deassertion both outrank a beat arriving in the same cycle
  assign wr_en     = (state == CAPTURE) & beat & ~clear & en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      s_axis_tready <= 1'b0;
      wr_addr       <= '0;
      idx           <= '0;
      frame_cnt     <= '0;
      full          <= 1'b0;
      capturing     <= 1'b0;
      tlast_err     <= 1'b0;
    end else begin
      s_axis_tready <= 1'b1;
      if (clear) begin
        state     <= IDLE;
        wr_addr   <= '0;
        idx       <= '0;
        frame_cnt <= '0;
        full      <= 1'b0;
        capturing <= 1'b0;
        tlast_err <= 1'b0;
      end else if (!en && (state == ALIGN || state == CAPTURE)) begin
        state     <= IDLE;
        wr_addr   <= '0;
        idx       <= '0;
        frame_cnt <= '0;
        capturing <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (en) begin
              if (ALIGN_TLAST != 0) begin
                state <= ALIGN;
              end else begin
                state     <= CAPTURE;
                capturing <= 1'b1;
              end
            end
          end
          ALIGN: begin
            // the tlast beat itself closes the previous frame and is not stored
            if (beat && s_axis_tlast) begin
              state     <= CAPTURE;
              capturing <= 1'b1;
            end
          end
          CAPTURE: begin
            if (beat) begin
              wr_addr <= wr_addr + AW'(1);
              idx     <= last_idx ? '0 : idx + IW'(1);
              if (last_idx)
                frame_cnt <= frame_cnt + FW'(1);
              if (last_idx != s_axis_tlast)
                tlast_err <= 1'b1;
              if (last_addr) begin
                state     <= FULL;
                full      <= 1'b1;
                capturing <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // simple dual-port RAM: one write port, registered read with read-before-write
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= s_axis_tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else
      rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_axis_frame_capture.sv
// Directed bench for axis_frame_capture with FFT_LEN=8, FRAMES=4; a second
// instance with ALIGN_TLAST=0 shares the stimulus.
module tb_axis_frame_capture;

  localparam int W  = 16;
  localparam int FL = 8;
  localparam int FR = 4;
  localparam int S  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [4:0]  rd_addr = '0;

  logic        tready, full, capturing, tlast_err;
  logic [31:0] rd_data;
  logic [2:0]  frame_cnt;
  logic        tready_v, full_v, capturing_v, tlast_err_v;
  logic [31:0] rd_data_v;
  logic [2:0]  frame_cnt_v;

  axis_frame_capture #(.WIDTH(W), .FFT_LEN(FL), .FRAMES(FR), .SAMP(S), .ALIGN_TLAST(1)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(tready), .rd_addr(rd_addr), .rd_data(rd_data),
    .full(full), .capturing(capturing), .frame_cnt(frame_cnt), .tlast_err(tlast_err)
  );

  axis_frame_capture #(.WIDTH(W), .FFT_LEN(FL), .FRAMES(FR), .SAMP(S), .ALIGN_TLAST(0)) dut_v (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(tready_v), .rd_addr(rd_addr), .rd_data(rd_data_v),
    .full(full_v), .capturing(capturing_v), .frame_cnt(frame_cnt_v), .tlast_err(tlast_err_v)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int full_at, full_v_at, err_at, prev;
  int rdy_low = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp_m;
    logic [31:0] exp_v;
  } rb_t;
  rb_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // records the last consumed stream value at which each flag was first seen high
  task automatic observe();
    if (full && full_at < 0) full_at = prev;
    if (full_v && full_v_at < 0) full_v_at = prev;
    if (tlast_err && err_at < 0) err_at = prev;
    if (!tready) rdy_low++;
  endtask

  task automatic stream(input logic [15:0] tag, input int n, input bit gap,
                        input int drop_v, input int inj_v);
    prev = -1; full_at = -1; full_v_at = -1; err_at = -1;
    for (int v = 0; v < n; v++) begin
      @(negedge clk); observe();
      tdata  = {tag, 16'(v)};
      tvalid = 1'b1;
      tlast  = (((v % FL) == FL - 1) && (v != drop_v)) || (v == inj_v);
      prev   = v;
      if (gap) begin
        @(negedge clk); observe();
        tvalid = 1'b0; tlast = 1'b0;
      end
    end
    @(negedge clk); observe();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk); rd_addr = a;
    @(negedge clk); chk(name, rd_data, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{5'd0,  32'd8,  32'd0};
    tbl[1] = '{5'd1,  32'd9,  32'd1};
    tbl[2] = '{5'd7,  32'd15, 32'd7};
    tbl[3] = '{5'd8,  32'd16, 32'd8};
    tbl[4] = '{5'd30, 32'd38, 32'd30};
    tbl[5] = '{5'd31, 32'd39, 32'd31};

    #12;
    chk("rst_tready", tready, 0);
    chk("rst_full", full, 0);
    chk("rst_capturing", capturing, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_tlast_err", tlast_err, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("tready_after_rst", tready, 1);
    chk("idle_capturing", capturing, 0);
    en = 1'b1;
    @(negedge clk);
    chk("align_capturing", capturing, 0);
    chk("noalign_capturing", capturing_v, 1);

    // aligned capture, with the ALIGN_TLAST=0 instance capturing from value 0
    stream(16'h0, 64, 1'b0, -1, -1);
    chk("s1_full_at", full_at, 39);
    chk("s1_full", full, 1);
    chk("s1_frame_cnt", frame_cnt, FR);
    chk("s1_tlast_err", tlast_err, 0);
    chk("s1_capturing", capturing, 0);
    chk("s6_full_at", full_v_at, 31);
    chk("s6_frame_cnt", frame_cnt_v, FR);
    chk("s6_tlast_err", tlast_err_v, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); rd_addr = tbl[i].addr;
      @(negedge clk);
      chk($sformatf("tbl_main_%0d", tbl[i].addr), rd_data, tbl[i].exp_m);
      chk($sformatf("tbl_var_%0d", tbl[i].addr), rd_data_v, tbl[i].exp_v);
    end
    for (int a = 0; a < S; a++)
      rd_chk($sformatf("s1_ram_%0d", a), 5'(a), {16'h0, 16'(a + 8)});

    // clear while FULL, with a beat in the same cycle
    @(negedge clk); clear = 1'b1; tvalid = 1'b1; tlast = 1'b1; tdata = 32'hDEADBEEF;
    @(negedge clk); clear = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    chk("clr_full", full, 0);
    chk("clr_capturing", capturing, 0);
    chk("clr_frame_cnt", frame_cnt, 0);
    rd_chk("clr_ram_0", 5'd0, 32'h8);
    rd_chk("clr_ram_31", 5'd31, 32'd39);

    // gapped tvalid
    stream(16'h1, 64, 1'b1, -1, -1);
    chk("s2_full_at", full_at, 39);
    chk("s2_frame_cnt", frame_cnt, FR);
    chk("s2_tready_low", rdy_low, 0);
    chk("s2_tlast_err", tlast_err, 0);
    for (int a = 0; a < S; a++)
      rd_chk($sformatf("s2_ram_%0d", a), 5'(a), {16'h1, 16'(a + 8)});

    // missing tlast at the end of captured frame 1 (value 23)
    pulse_clear();
    stream(16'h2, 64, 1'b0, 23, -1);
    chk("s3a_err_at", err_at, 23);
    chk("s3a_full_at", full_at, 39);
    chk("s3a_frame_cnt", frame_cnt, FR);

    // unexpected tlast at in-frame index 3 (value 11)
    pulse_clear();
    chk("s3b_err_cleared", tlast_err, 0);
    stream(16'h3, 64, 1'b0, -1, 11);
    chk("s3b_err_at", err_at, 11);
    chk("s3b_full_at", full_at, 39);

    // abort after 10 captured beats, then re-enable
    pulse_clear();
    stream(16'h4, 18, 1'b0, -1, -1);
    chk("s4_pre_capturing", capturing, 1);
    chk("s4_pre_frame_cnt", frame_cnt, 1);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    chk("s4_abort_capturing", capturing, 0);
    chk("s4_abort_frame_cnt", frame_cnt, 0);
    en = 1'b1;
    stream(16'h5, 64, 1'b0, -1, -1);
    chk("s4_full_at", full_at, 39);
    rd_chk("s4_ram_0", 5'd0, {16'h5, 16'd8});
    rd_chk("s4_ram_9", 5'd9, {16'h5, 16'd17});

    // asynchronous reset in the middle of a capture
    pulse_clear();
    stream(16'h6, 20, 1'b0, -1, 10);
    chk("s5_pre_err", tlast_err, 1);
    chk("s5_pre_capturing", capturing, 1);
    #2 rst = 1'b1;
    #1;
    chk("s5_tready", tready, 0);
    chk("s5_full", full, 0);
    chk("s5_capturing", capturing, 0);
    chk("s5_frame_cnt", frame_cnt, 0);
    chk("s5_tlast_err", tlast_err, 0);
    chk("s5_rd_data", rd_data, 0);
    en = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("s5_tready_rel", tready, 1);
    chk("s5_idle", capturing, 0);
    stream(16'h7, 64, 1'b0, -1, -1);
    chk("s5_disarmed_full", full_at, -1);
    chk("s5_disarmed_cap", capturing, 0);
    rd_chk("s5_ram_0", 5'd0, {16'h6, 16'd8});
    rd_chk("s5_ram_11", 5'd11, {16'h6, 16'd19});
    en = 1'b1;
    stream(16'h8, 64, 1'b0, -1, -1);
    chk("s5_rearm_full_at", full_at, 39);
    rd_chk("s5_rearm_ram_0", 5'd0, {16'h8, 16'd8});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
